kbd_ascii_decoder: RTL and testbench

- Sits directly downstream of ps2_keyboard_controller and consumes its byte-FIFO interface (data, ready, nextdata_n).
- Parses raw PS/2 set-2 bytes, including the F0 (break) and E0 (extended) prefixes, into complete key events.
- Tracks shift and caps-lock state, translates each event to ASCII, and presents it on a valid/ready handshake for display or CPU-side consumers.
- Keeps a running count of distinct key presses.

---
 rtl/kbd_pkg.sv | 28 ++
 rtl/kbd_scan2ascii.sv | 84 ++++++++
 rtl/kbd_ascii_decoder.sv | 169 ++++++++++++++++
 tb/tb_kbd_ascii_decoder.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared constants, FSM state type and key-event record for the PS/2 set-2 ASCII decoder.
package kbd_pkg;

  localparam logic [7:0] KBD_BRK    = 8'hF0;
  localparam logic [7:0] KBD_EXT    = 8'hE0;
  localparam logic [7:0] KBD_LSHIFT = 8'h12;
  localparam logic [7:0] KBD_RSHIFT = 8'h59;
  localparam logic [7:0] KBD_CAPS   = 8'h58;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_POP    = 2'd1,
    ST_DECODE = 2'd2,
    ST_EMIT   = 2'd3
  } kbd_state_e;

  typedef struct packed {
    logic [7:0] scan;
    logic [7:0] ascii;
    logic       brk;
    logic       ext;
  } kbd_evt_t;

  function automatic logic kbd_is_shift(input logic [7:0] scan);
    return (scan == KBD_LSHIFT) || (scan == KBD_RSHIFT);
  endfunction

endpackage

// File: rtl/kbd_scan2ascii.sv
// Combinational set-2 scancode to ASCII ROM; extended codes and unmapped keys give 8'h00.
module kbd_scan2ascii (
  input  logic [7:0] scan_i,
  input  logic       ext_i,
  input  logic       shift_i,
  input  logic       caps_i,
  output logic [7:0] ascii_o
);

  logic       alpha;
  logic [7:0] lo;
  logic [7:0] hi;

  always_comb begin
    alpha = 1'b0;
    lo    = 8'h00;
    hi    = 8'h00;
    case (scan_i)
      8'h1C: {alpha, lo, hi} = {1'b1, "a", "A"};
      8'h32: {alpha, lo, hi} = {1'b1, "b", "B"};
      8'h21: {alpha, lo, hi} = {1'b1, "c", "C"};
      8'h23: {alpha, lo, hi} = {1'b1, "d", "D"};
      8'h24: {alpha, lo, hi} = {1'b1, "e", "E"};
      8'h2B: {alpha, lo, hi} = {1'b1, "f", "F"};
      8'h34: {alpha, lo, hi} = {1'b1, "g", "G"};
      8'h33: {alpha, lo, hi} = {1'b1, "h", "H"};
      8'h43: {alpha, lo, hi} = {1'b1, "i", "I"};
      8'h3B: {alpha, lo, hi} = {1'b1, "j", "J"};
      8'h42: {alpha, lo, hi} = {1'b1, "k", "K"};
      8'h4B: {alpha, lo, hi} = {1'b1, "l", "L"};
      8'h3A: {alpha, lo, hi} = {1'b1, "m", "M"};
      8'h31: {alpha, lo, hi} = {1'b1, "n", "N"};
      8'h44: {alpha, lo, hi} = {1'b1, "o", "O"};
      8'h4D: {alpha, lo, hi} = {1'b1, "p", "P"};
      8'h15: {alpha, lo, hi} = {1'b1, "q", "Q"};
      8'h2D: {alpha, lo, hi} = {1'b1, "r", "R"};
      8'h1B: {alpha, lo, hi} = {1'b1, "s", "S"};
      8'h2C: {alpha, lo, hi} = {1'b1, "t", "T"};
      8'h3C: {alpha, lo, hi} = {1'b1, "u", "U"};
      8'h2A: {alpha, lo, hi} = {1'b1, "v", "V"};
      8'h1D: {alpha, lo, hi} = {1'b1, "w", "W"};
      8'h22: {alpha, lo, hi} = {1'b1, "x", "X"};
      8'h35: {alpha, lo, hi} = {1'b1, "y", "Y"};
      8'h1A: {alpha, lo, hi} = {1'b1, "z", "Z"};
      // Digit row: the shifted symbol follows US layout.
      8'h45: {lo, hi} = {8'h30, 8'h29};
      8'h16: {lo, hi} = {8'h31, 8'h21};
      8'h1E: {lo, hi} = {8'h32, 8'h40};
      8'h26: {lo, hi} = {8'h33, 8'h23};
      8'h25: {lo, hi} = {8'h34, 8'h24};
      8'h2E: {lo, hi} = {8'h35, 8'h25};
      8'h36: {lo, hi} = {8'h36, 8'h5E};
      8'h3D: {lo, hi} = {8'h37, 8'h26};
      8'h3E: {lo, hi} = {8'h38, 8'h2A};
      8'h46: {lo, hi} = {8'h39, 8'h28};
      8'h0E: {lo, hi} = {8'h60, 8'h7E};
      8'h4E: {lo, hi} = {8'h2D, 8'h5F};
      8'h55: {lo, hi} = {8'h3D, 8'h2B};
      8'h54: {lo, hi} = {8'h5B, 8'h7B};
      8'h5B: {lo, hi} = {8'h5D, 8'h7D};
      8'h5D: {lo, hi} = {8'h5C, 8'h7C};
      8'h4C: {lo, hi} = {8'h3B, 8'h3A};
      8'h52: {lo, hi} = {8'h27, 8'h22};
      8'h41: {lo, hi} = {8'h2C, 8'h3C};
      8'h49: {lo, hi} = {8'h2E, 8'h3E};
      8'h4A: {lo, hi} = {8'h2F, 8'h3F};
      8'h29: {lo, hi} = {8'h20, 8'h20};
      8'h5A: {lo, hi} = {8'h0D, 8'h0D};
      8'h66: {lo, hi} = {8'h08, 8'h08};
      8'h0D: {lo, hi} = {8'h09, 8'h09};
      8'h76: {lo, hi} = {8'h1B, 8'h1B};
      default: ;
    endcase
  end

  always_comb begin
    ascii_o = 8'h00;
    if (!ext_i) begin
      if (alpha) ascii_o = (shift_i ^ caps_i) ? hi : lo;
      else       ascii_o = shift_i ? hi : lo;
    end
  end

endmodule

// File: rtl/kbd_ascii_decoder.sv
// PS/2 set-2 byte stream to ASCII key-event decoder with shift/caps tracking and press counting.
// Build option: define KBD_REPEAT_FILTER_EN to drop typematic repeats of the held key.
module kbd_ascii_decoder
  import kbd_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       kbd_data,
  input  logic             kbd_ready,
  output logic             nextdata_n,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_scan,
  output logic [7:0]       evt_ascii,
  output logic             evt_break,
  output logic             evt_ext,
  output logic             shift,
  output logic             caps,
  output logic [CNT_W-1:0] press_cnt
);

  // Handshake: an event transfers on a rising clk edge where evt_valid and
  // evt_ready are both high; once raised, evt_valid and all evt_* fields stay
  // stable until that transfer, and no controller bytes are popped meanwhile.

  kbd_state_e       state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             nd_q, nd_d;
  logic             brk_f_q, brk_f_d;
  logic             ext_f_q, ext_f_d;
  kbd_evt_t         evt_q, evt_d;
  logic             valid_q, valid_d;
  logic             shift_q, shift_d;
  logic             caps_q, caps_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       held_q, held_d;
  logic             held_vld_q, held_vld_d;

  logic [7:0]       rom_ascii;
  logic             is_held;
  logic             is_shift_key;

  kbd_scan2ascii u_rom (
    .scan_i  (byte_q),
    .ext_i   (ext_f_q),
    .shift_i (shift_q),
    .caps_i  (caps_q),
    .ascii_o (rom_ascii)
  );

  assign is_held      = held_vld_q && (held_q == {ext_f_q, byte_q});
  assign is_shift_key = kbd_is_shift(byte_q);

  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    nd_d       = nd_q;
    brk_f_d    = brk_f_q;
    ext_f_d    = ext_f_q;
    evt_d      = evt_q;
    valid_d    = valid_q;
    shift_d    = shift_q;
    caps_d     = caps_q;
    cnt_d      = cnt_q;
    held_d     = held_q;
    held_vld_d = held_vld_q;
    case (state_q)
      ST_IDLE: begin
        if (kbd_ready) begin
          byte_d  = kbd_data;
          nd_d    = 1'b0;
          state_d = ST_POP;
        end
      end
      ST_POP: begin
        nd_d    = 1'b1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (byte_q == KBD_BRK) begin
          brk_f_d = 1'b1;
          state_d = ST_IDLE;
        end else if (byte_q == KBD_EXT) begin
          ext_f_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          brk_f_d = 1'b0;
          ext_f_d = 1'b0;
          if (!brk_f_q) begin
            if (is_shift_key) shift_d = 1'b1;
            // A repeat of the held key is neither a new press nor a caps toggle.
            if (!is_held) begin
              cnt_d      = cnt_q + CNT_W'(1);
              held_d     = {ext_f_q, byte_q};
              held_vld_d = 1'b1;
              if (byte_q == KBD_CAPS) caps_d = ~caps_q;
            end
          end else begin
            if (is_shift_key) shift_d = 1'b0;
            if (is_held) held_vld_d = 1'b0;
          end
`ifdef KBD_REPEAT_FILTER_EN
          if (!brk_f_q && is_held) begin
            state_d = ST_IDLE;
          end else begin
            evt_d   = '{scan: byte_q, ascii: rom_ascii, brk: brk_f_q, ext: ext_f_q};
            valid_d = 1'b1;
            state_d = ST_EMIT;
          end
`else
          evt_d   = '{scan: byte_q, ascii: rom_ascii, brk: brk_f_q, ext: ext_f_q};
          valid_d = 1'b1;
          state_d = ST_EMIT;
`endif
        end
      end
      ST_EMIT: begin
        if (valid_q && evt_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= ST_IDLE;
      byte_q     <= 8'h00;
      nd_q       <= 1'b1;
      brk_f_q    <= 1'b0;
      ext_f_q    <= 1'b0;
      evt_q      <= '0;
      valid_q    <= 1'b0;
      shift_q    <= 1'b0;
      caps_q     <= 1'b0;
      cnt_q      <= '0;
      held_q     <= 9'd0;
      held_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      nd_q       <= nd_d;
      brk_f_q    <= brk_f_d;
      ext_f_q    <= ext_f_d;
      evt_q      <= evt_d;
      valid_q    <= valid_d;
      shift_q    <= shift_d;
      caps_q     <= caps_d;
      cnt_q      <= cnt_d;
      held_q     <= held_d;
      held_vld_q <= held_vld_d;
    end
  end

  assign nextdata_n = nd_q;
  assign evt_valid  = valid_q;
  assign evt_scan   = evt_q.scan;
  assign evt_ascii  = evt_q.ascii;
  assign evt_break  = evt_q.brk;
  assign evt_ext    = evt_q.ext;
  assign shift      = shift_q;
  assign caps       = caps_q;
  assign press_cnt  = cnt_q;

endmodule

// File: tb/tb_kbd_ascii_decoder.sv
// Bench for kbd_ascii_decoder: FIFO-style controller model, random consumer back-pressure,
// and a key-table reference model that predicts every event and the shift/caps/count state.
module tb_kbd_ascii_decoder;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             clrn;
  logic [7:0]       kbd_data;
  logic             kbd_ready;
  logic             nextdata_n;
  logic             evt_valid;
  logic             evt_ready;
  logic [7:0]       evt_scan;
  logic [7:0]       evt_ascii;
  logic             evt_break;
  logic             evt_ext;
  logic             shift;
  logic             caps;
  logic [CNT_W-1:0] press_cnt;

  kbd_ascii_decoder #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .kbd_data   (kbd_data),
    .kbd_ready  (kbd_ready),
    .nextdata_n (nextdata_n),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_scan   (evt_scan),
    .evt_ascii  (evt_ascii),
    .evt_break  (evt_break),
    .evt_ext    (evt_ext),
    .shift      (shift),
    .caps       (caps),
    .press_cnt  (press_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- key tables (reference) ----------------
  logic [7:0] letter_sc [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,
                                 8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,
                                 8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  logic [7:0] digit_sc  [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
  logic [7:0] digit_hi  [10] = '{8'h29,8'h21,8'h40,8'h23,8'h24,8'h25,8'h5E,8'h26,8'h2A,8'h28};
  logic [7:0] punct_sc  [16] = '{8'h0E,8'h4E,8'h55,8'h54,8'h5B,8'h5D,8'h4C,8'h52,8'h41,8'h49,
                                 8'h4A,8'h29,8'h5A,8'h66,8'h0D,8'h76};
  logic [7:0] punct_lo  [16] = '{8'h60,8'h2D,8'h3D,8'h5B,8'h5D,8'h5C,8'h3B,8'h27,8'h2C,8'h2E,
                                 8'h2F,8'h20,8'h0D,8'h08,8'h09,8'h1B};
  logic [7:0] punct_hi  [16] = '{8'h7E,8'h5F,8'h2B,8'h7B,8'h7D,8'h7C,8'h3A,8'h22,8'h3C,8'h3E,
                                 8'h3F,8'h20,8'h0D,8'h08,8'h09,8'h1B};

  function automatic logic [7:0] ascii_of(input logic [7:0] sc, input bit ext,
                                          input bit sh, input bit cp);
    if (ext) return 8'h00;
    for (int i = 0; i < 26; i++)
      if (letter_sc[i] == sc) return 8'((sh ^ cp) ? 65 + i : 97 + i);
    for (int i = 0; i < 10; i++)
      if (digit_sc[i] == sc) return sh ? digit_hi[i] : 8'(48 + i);
    for (int i = 0; i < 16; i++)
      if (punct_sc[i] == sc) return sh ? punct_hi[i] : punct_lo[i];
    return 8'h00;
  endfunction

  // ---------------- reference model state ----------------
  bit       m_brk, m_ext, m_shift, m_caps, m_held_vld;
  int       m_cnt;
  logic [8:0] m_held;

  // Expected event word: {scan, ascii, brk, ext, shift, caps, press_cnt}
  logic [27:0] exp_q[$];
  logic [7:0]  fifo_q[$];

  task automatic model_reset();
    m_brk = 0; m_ext = 0; m_shift = 0; m_caps = 0; m_held_vld = 0; m_cnt = 0; m_held = 9'd0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit rep;
    bit filtered;
    logic [7:0] a;
    if (b == 8'hF0) begin m_brk = 1; return; end
    if (b == 8'hE0) begin m_ext = 1; return; end
    rep = m_held_vld && (m_held == {m_ext, b});
    a   = ascii_of(b, m_ext, m_shift, m_caps);
    filtered = 0;
    if (!m_brk) begin
      if (b == 8'h12 || b == 8'h59) m_shift = 1;
      if (!rep) begin
        m_cnt = (m_cnt + 1) % 256;
        m_held = {m_ext, b};
        m_held_vld = 1;
        if (b == 8'h58) m_caps = !m_caps;
      end
`ifdef KBD_REPEAT_FILTER_EN
      filtered = rep;
`endif
    end else begin
      if (b == 8'h12 || b == 8'h59) m_shift = 0;
      if (rep) m_held_vld = 0;
    end
    if (!filtered)
      exp_q.push_back({b, a, m_brk, m_ext, m_shift, m_caps, 8'(m_cnt)});
    m_brk = 0;
    m_ext = 0;
  endtask

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver / monitor ----------------
  int          rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled
  int          pulses   = 0;
  int          n_evts   = 0;
  bit          prev_low = 0;
  logic [27:0] last_acc = '0;

  task automatic feed(input logic [7:0] b);
    fifo_q.push_back(b);
    model_byte(b);
  endtask

  task automatic step();
    logic [27:0] got;
    @(negedge clk);
    if (!nextdata_n) begin
      chk("nextdata_n_one_cycle", 32'(prev_low), 32'd0);
      pulses++;
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    prev_low  = !nextdata_n;
    kbd_ready = (fifo_q.size() != 0);
    kbd_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    case (rdy_mode)
      0:       evt_ready = 1'b1;
      1:       evt_ready = ($urandom_range(0, 2) != 0);
      default: evt_ready = 1'b0;
    endcase
    if (evt_valid) begin
      got = {evt_scan, evt_ascii, evt_break, evt_ext, shift, caps, press_cnt};
      if (exp_q.size() == 0) chk("unexpected_event", 32'(got), 32'h0);
      else                   chk("event", 32'(got), 32'(exp_q[0]));
      if (evt_ready) begin
        last_acc = got;
        n_evts++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) begin
      chk("drain_timeout", 32'(fifo_q.size() + exp_q.size()), 32'd0);
      fifo_q.delete();
      exp_q.delete();
    end
    repeat (4) step();
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_shift"}, 32'(shift), 32'(m_shift));
    chk({tag, "_caps"},  32'(caps),  32'(m_caps));
    chk({tag, "_cnt"},   32'(press_cnt), 32'(m_cnt));
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    model_reset();
    #1;
    chk("rst_nextdata_n", 32'(nextdata_n), 32'd1);
    chk("rst_evt_valid",  32'(evt_valid),  32'd0);
    chk("rst_fields", 32'({evt_scan, evt_ascii, evt_break, evt_ext}), 32'd0);
    chk("rst_state",  32'({shift, caps, press_cnt}), 32'd0);
    repeat (2) step();
    clrn = 1'b1;
    repeat (2) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p0, e0, lat;
    logic [7:0] c0;
    logic [7:0] sc, last_sc;
    bit ext_k, brk_k;
    clrn = 1'b0; kbd_data = 8'h00; kbd_ready = 1'b0; evt_ready = 1'b1;
    model_reset();
    repeat (3) step();
    do_reset();

    // Make and break of 'a'
    p0 = pulses;
    feed(8'h1C); feed(8'hF0); feed(8'h1C);
    drain();
    chk("t1_pulses", 32'(pulses - p0), 32'd3);
    chk("t1_break_evt", 32'(last_acc[27:10]), 32'({8'h1C, 8'h61, 1'b1, 1'b0}));
    chk("t1_cnt", 32'(press_cnt), 32'd1);

    // Shifted letter
    feed(8'h12); feed(8'h1C);
    drain();
    chk("t2_upper", 32'(last_acc[27:9]), 32'({8'h1C, 8'h41, 1'b0, 1'b0, 1'b1}));
    feed(8'hF0); feed(8'h1C); feed(8'hF0); feed(8'h12);
    drain();
    chk("t2_shift_released", 32'(shift), 32'd0);

    // Caps lock toggling
    feed(8'h58); feed(8'hF0); feed(8'h58); feed(8'h1C);
    drain();
    chk("t3_caps_on", 32'(caps), 32'd1);
    chk("t3_ascii", 32'(last_acc[19:12]), 32'h41);
    feed(8'hF0); feed(8'h1C); feed(8'h58); feed(8'hF0); feed(8'h58);
    drain();
    chk("t3_caps_off", 32'(caps), 32'd0);

    // Typematic repeats
    e0 = n_evts; c0 = press_cnt;
    feed(8'h1C); feed(8'h1C); feed(8'h1C); feed(8'hF0); feed(8'h1C);
    drain();
`ifdef KBD_REPEAT_FILTER_EN
    chk("t4_events", 32'(n_evts - e0), 32'd2);
`else
    chk("t4_events", 32'(n_evts - e0), 32'd4);
`endif
    chk("t4_cnt_delta", 32'(8'(press_cnt - c0)), 32'd1);

    // Back-pressure: consumer stalls while three bytes wait in the controller
    rdy_mode = 2;
    p0 = pulses;
    feed(8'h32); feed(8'hF0); feed(8'h32); feed(8'h21);
    repeat (25) step();
    chk("t5_valid_held", 32'(evt_valid), 32'd1);
    chk("t5_fifo_left", 32'(fifo_q.size()), 32'd3);
    chk("t5_pulses", 32'(pulses - p0), 32'd1);
    rdy_mode = 0;
    drain();
    chk("t5_order_last", 32'(last_acc[27:20]), 32'h21);
    feed(8'hF0); feed(8'h21);
    drain();

    // Extended break with E0 before F0, and F0 before E0
    feed(8'hE0); feed(8'hF0); feed(8'h75);
    drain();
    chk("t6_ext_break", 32'(last_acc[27:10]), 32'({8'h75, 8'h00, 1'b1, 1'b1}));
    feed(8'hF0); feed(8'hF0); feed(8'hE0); feed(8'h6B);
    drain();
    chk("t6_dup_f0", 32'(last_acc[27:10]), 32'({8'h6B, 8'h00, 1'b1, 1'b1}));

    // Latency from kbd_ready in IDLE to evt_valid
    feed(8'h24);
    step();
    lat = 0;
    while (!evt_valid && lat < 10) begin
      step();
      lat++;
    end
    chk("t7_latency", 32'(lat), 32'd3);
    drain();

    // Reset after a lone E0 discards the prefix
    feed(8'hE0);
    drain();
    do_reset();
    feed(8'h1C);
    drain();
    chk("t8_after_reset", 32'(last_acc[27:10]), 32'({8'h1C, 8'h61, 1'b0, 1'b0}));
    chk("t8_cnt", 32'(press_cnt), 32'd1);

    // Reset while an event is pending
    rdy_mode = 2;
    feed(8'h32);
    repeat (8) step();
    do_reset();
    rdy_mode = 0;
    check_state("t8b");

    // press_cnt wraps after 256 distinct presses
    for (int i = 0; i < 256; i++) feed((i % 2 == 0) ? 8'h1C : 8'h32);
    drain();
    chk("t9_wrap", 32'(press_cnt), 32'd0);
    feed(8'hF0); feed(8'h32);
    drain();

    // Randomized key traffic with random consumer stalls
    rdy_mode = 1;
    last_sc = 8'h1C;
    for (int n = 0; n < 300; n++) begin
      int kind, r;
      kind  = $urandom_range(0, 9);
      ext_k = 0;
      if (kind < 6) begin
        r = $urandom_range(0, 51);
        if (r < 26)      sc = letter_sc[r];
        else if (r < 36) sc = digit_sc[r - 26];
        else             sc = punct_sc[r - 36];
      end else if (kind == 6) sc = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
      else if (kind == 7) sc = 8'h58;
      else if (kind == 8) begin
        sc = ($urandom_range(0, 1) != 0) ? 8'h75 : 8'h6B;
        ext_k = 1;
      end else sc = last_sc;
      brk_k = ($urandom_range(0, 2) == 0);
      if (ext_k && brk_k && $urandom_range(0, 1) != 0) begin
        feed(8'hF0); feed(8'hE0);
      end else begin
        if (ext_k) feed(8'hE0);
        if (brk_k) begin
          feed(8'hF0);
          if ($urandom_range(0, 7) == 0) feed(8'hF0);
        end
      end
      feed(sc);
      if (!ext_k) last_sc = sc;
      if (n % 20 == 19) drain();
    end
    drain();
    check_state("t10_final");
    chk("t10_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
